vram_scanout: RTL and testbench

- Read-side master for the 2-bit pixel VRAM.
- Generates 640x480@60 VGA-style timing. Walks the stored 160x144 Game Boy frame, upscaled by an integer factor and centred, issuing RdAddress/RdClockEn to the VRAM.
- Maps the returned 2-bit pixel through the DMG palette onto 24-bit RGB with aligned Hsync/Vsync/De.
- Sits between the VRAM read port and the display output pins.

---
 rtl/vram_scanout.sv | 270 +++++++++++++++++++++++++++
 tb/tb_vram_scanout.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_scanout.sv
// ============================================================================
//  Module      : vram_scanout
//  Description : VGA-style scan-out master for a 2-bit Game Boy frame buffer.
//                It generates 640x480@60 timing, walks the 160x144 image
//                (integer upscaled and centred) with VRAM read requests, and
//                maps the returned pixels through the DMG palette onto
//                24-bit RGB with aligned Hsync/Vsync/De/FrameStart.
//                The pipeline has three stages from counters to output pins.
//  Options     : define SCANOUT_SCANLINES_EN to halve the brightness of the
//                last output line of every scaled image row.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SCALE    = 3,
    parameter int IMG_W    = 160,
    parameter int IMG_H    = 144,
    parameter int X_OFF    = 80,
    parameter int Y_OFF    = 24
) (
    input  logic        RdClock,
    input  logic        Reset,
    output logic [15:0] RdAddress,
    output logic        RdClockEn,
    input  logic [1:0]  Q,
    output logic        Hsync,
    output logic        Vsync,
    output logic        De,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        FrameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] c_h_last  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] c_h_act   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] c_hs_beg  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] c_hs_end  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] c_x_beg   = HW'(X_OFF);
    localparam logic [HW-1:0] c_x_end   = HW'(X_OFF + IMG_W * SCALE);

    localparam logic [VW-1:0] c_v_last  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] c_v_act   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] c_vs_beg  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] c_vs_end  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] c_y_beg   = VW'(Y_OFF);
    localparam logic [VW-1:0] c_y_end   = VW'(Y_OFF + IMG_H * SCALE);

    localparam logic [1:0]    c_sub_last   = 2'(SCALE - 1);
    localparam logic [7:0]    c_img_w_last = 8'(IMG_W - 1);
    localparam logic [7:0]    c_img_h_last = 8'(IMG_H - 1);

    // ------------------------------------------------------------------
    // S0: raster and image-coordinate counters
    // ------------------------------------------------------------------
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [1:0]    r_xsub;
    logic [1:0]    r_ysub;
    logic [7:0]    r_img_x;
    logic [7:0]    r_img_y;

    logic w_h_last;
    logic w_v_last;
    logic w_h_win;
    logic w_v_win;
    logic w_win;
    logic w_de;
    logic w_hs_n;
    logic w_vs_n;
    logic w_fs;

    assign w_h_last = (r_hcnt == c_h_last);
    assign w_v_last = (r_vcnt == c_v_last);
    assign w_h_win  = (r_hcnt >= c_x_beg) && (r_hcnt < c_x_end);
    assign w_v_win  = (r_vcnt >= c_y_beg) && (r_vcnt < c_y_end);
    assign w_win    = w_h_win && w_v_win;
    assign w_de     = (r_hcnt < c_h_act) && (r_vcnt < c_v_act);
    assign w_hs_n   = !((r_hcnt >= c_hs_beg) && (r_hcnt < c_hs_end));
    assign w_vs_n   = !((r_vcnt >= c_vs_beg) && (r_vcnt < c_vs_end));
    assign w_fs     = (r_hcnt == '0) && (r_vcnt == '0);

    // Raster position plus scaled image coordinates; sub-counters replace division
    always_ff @(posedge RdClock) begin
        if (Reset) begin
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_xsub  <= '0;
            r_ysub  <= '0;
            r_img_x <= '0;
            r_img_y <= '0;
        end else begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end

            // Horizontal image coordinate is held at zero outside the window,
            // so the first window column always starts at img_x = 0.
            if (!w_h_win) begin
                r_xsub  <= '0;
                r_img_x <= '0;
            end else if (r_xsub == c_sub_last) begin
                r_xsub  <= '0;
                r_img_x <= (r_img_x == c_img_w_last) ? '0 : r_img_x + 1'b1;
            end else begin
                r_xsub  <= r_xsub + 1'b1;
            end

            // Vertical image coordinate steps once per line, at its end.
            if (w_h_last) begin
                if (!w_v_win || w_v_last) begin
                    r_ysub  <= '0;
                    r_img_y <= '0;
                end else if (r_ysub == c_sub_last) begin
                    r_ysub  <= '0;
                    r_img_y <= (r_img_y == c_img_h_last) ? '0 : r_img_y + 1'b1;
                end else begin
                    r_ysub  <= r_ysub + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: VRAM request and delayed raster flags
    // ------------------------------------------------------------------
    logic r_s1_win;
    logic r_s1_de;
    logic r_s1_hs;
    logic r_s1_vs;
    logic r_s1_fs;
`ifdef SCANOUT_SCANLINES_EN
    logic r_s1_dim;
`endif

    // Issue a read only inside the image; the address is held otherwise
    always_ff @(posedge RdClock) begin
        if (Reset) begin
            RdAddress <= '0;
            RdClockEn <= 1'b0;
            r_s1_win  <= 1'b0;
            r_s1_de   <= 1'b0;
            r_s1_hs   <= 1'b1;
            r_s1_vs   <= 1'b1;
            r_s1_fs   <= 1'b0;
`ifdef SCANOUT_SCANLINES_EN
            r_s1_dim  <= 1'b0;
`endif
        end else begin
            RdClockEn <= w_win;
            if (w_win) begin
                RdAddress <= {r_img_y, r_img_x};
            end
            r_s1_win  <= w_win;
            r_s1_de   <= w_de;
            r_s1_hs   <= w_hs_n;
            r_s1_vs   <= w_vs_n;
            r_s1_fs   <= w_fs;
`ifdef SCANOUT_SCANLINES_EN
            r_s1_dim  <= (r_ysub == c_sub_last);
`endif
        end
    end

    // ------------------------------------------------------------------
    // S2: VRAM data arrives; flags follow in parallel
    // ------------------------------------------------------------------
    logic r_s2_win;
    logic r_s2_de;
    logic r_s2_hs;
    logic r_s2_vs;
    logic r_s2_fs;
`ifdef SCANOUT_SCANLINES_EN
    logic r_s2_dim;
`endif

    // Delay the raster flags to line up with the returning VRAM data
    always_ff @(posedge RdClock) begin
        if (Reset) begin
            r_s2_win <= 1'b0;
            r_s2_de  <= 1'b0;
            r_s2_hs  <= 1'b1;
            r_s2_vs  <= 1'b1;
            r_s2_fs  <= 1'b0;
`ifdef SCANOUT_SCANLINES_EN
            r_s2_dim <= 1'b0;
`endif
        end else begin
            r_s2_win <= r_s1_win;
            r_s2_de  <= r_s1_de;
            r_s2_hs  <= r_s1_hs;
            r_s2_vs  <= r_s1_vs;
            r_s2_fs  <= r_s1_fs;
`ifdef SCANOUT_SCANLINES_EN
            r_s2_dim <= r_s1_dim;
`endif
        end
    end

    logic [23:0] w_pal;
    logic [23:0] w_rgb;

    // DMG green palette lookup of the returned pixel
    always_comb begin
        w_pal = 24'h000000;
        case (Q)
            2'd0:    w_pal = 24'hE0F8D0;
            2'd1:    w_pal = 24'h88C070;
            2'd2:    w_pal = 24'h346856;
            default: w_pal = 24'h081820;
        endcase
    end

`ifdef SCANOUT_SCANLINES_EN
    assign w_rgb = r_s2_dim ? {1'b0, w_pal[23:17], 1'b0, w_pal[15:9], 1'b0, w_pal[7:1]}
                            : w_pal;
`else
    assign w_rgb = w_pal;
`endif

    // ------------------------------------------------------------------
    // S3: registered output pins
    // ------------------------------------------------------------------
    // Border and blanking are forced black; image pixels take the palette
    always_ff @(posedge RdClock) begin
        if (Reset) begin
            Hsync      <= 1'b1;
            Vsync      <= 1'b1;
            De         <= 1'b0;
            Red        <= '0;
            Green      <= '0;
            Blue       <= '0;
            FrameStart <= 1'b0;
        end else begin
            Hsync      <= r_s2_hs;
            Vsync      <= r_s2_vs;
            De         <= r_s2_de;
            FrameStart <= r_s2_fs;
            if (r_s2_win) begin
                Red   <= w_rgb[23:16];
                Green <= w_rgb[15:8];
                Blue  <= w_rgb[7:0];
            end else begin
                Red   <= '0;
                Green <= '0;
                Blue  <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vram_scanout.sv
// ============================================================================
//  Module      : tb_vram_scanout
//  Description : Directed self-checking bench for vram_scanout, using a
//                reduced raster (80x48 total, 64x40 active, 16x10 image at
//                scale 3 placed at (8,5)) so whole frames stay short.
//                Cycle n counts clock periods since reset release; the
//                counters in cycle n sit at raster position n, RdAddress
//                reflects position n-1 and the output pins position n-3.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_scanout;

    logic        clk;
    logic        rst;
    logic [15:0] RdAddress;
    logic        RdClockEn;
    logic [1:0]  Q;
    logic        Hsync;
    logic        Vsync;
    logic        De;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;
    logic        FrameStart;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;

    vram_scanout #(
        .H_ACTIVE (64),
        .H_FP     (4),
        .H_SYNC   (8),
        .H_BP     (4),
        .V_ACTIVE (40),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (4),
        .SCALE    (3),
        .IMG_W    (16),
        .IMG_H    (10),
        .X_OFF    (8),
        .Y_OFF    (5)
    ) u_dut (
        .RdClock    (clk),
        .Reset      (rst),
        .RdAddress  (RdAddress),
        .RdClockEn  (RdClockEn),
        .Q          (Q),
        .Hsync      (Hsync),
        .Vsync      (Vsync),
        .De         (De),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue),
        .FrameStart (FrameStart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM model: registered read returning the low two address bits
    initial Q = 2'd0;
    always @(posedge clk) begin
        if (RdClockEn) Q <= RdAddress[1:0];
    end

    // Cycle counter relative to the last reset release
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, Red, Green, Blue};
    endfunction

    initial begin
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Reset state
        chk("rst_addr",  RdAddress, 16'h0000);
        chk("rst_en",    RdClockEn, 0);
        chk("rst_hs",    Hsync, 1);
        chk("rst_vs",    Vsync, 1);
        chk("rst_de",    De, 0);
        chk("rst_rgb",   rgb(), 0);
        chk("rst_fs",    FrameStart, 0);

        rst = 1'b0;

        // Start of first frame
        chk("c0_fs", FrameStart, 0);
        chk("c0_de", De, 0);
        goto(2);    chk("c2_fs", FrameStart, 0);
        goto(3);    chk("c3_fs", FrameStart, 1);
                    chk("c3_de", De, 1);
                    chk("c3_rgb", rgb(), 0);
        goto(4);    chk("c4_fs", FrameStart, 0);

        // Line timing: De ends after 64, Hsync low for h in [68,76)
        goto(66);   chk("de_last_act", De, 1);
        goto(67);   chk("de_first_blank", De, 0);
                    chk("rgb_blank", rgb(), 0);
        goto(70);   chk("hs_before", Hsync, 1);
        goto(71);   chk("hs_first", Hsync, 0);
        goto(78);   chk("hs_last", Hsync, 0);
        goto(79);   chk("hs_after", Hsync, 1);

        // Top border line 4
        goto(341);  chk("top_border_en", RdClockEn, 0);
        goto(343);  chk("top_border_de", De, 1);
                    chk("top_border_rgb", rgb(), 0);

        // First image line 5: reads from h=8
        goto(408);  chk("l5_en_before", RdClockEn, 0);
        goto(409);  chk("l5_en_first", RdClockEn, 1);
                    chk("l5_addr_first", RdAddress, 16'h0000);
        goto(410);  chk("l5_left_border_de", De, 1);
                    chk("l5_left_border_rgb", rgb(), 0);
        goto(411);  chk("l5_px0_rgb", rgb(), 24'hE0F8D0);
                    chk("l5_px0_de", De, 1);
                    chk("l5_addr_third", RdAddress, 16'h0000);
        goto(412);  chk("l5_addr_next", RdAddress, 16'h0001);
        goto(414);  chk("l5_px1_rgb", rgb(), 24'h88C070);
        goto(417);  chk("l5_px2_rgb", rgb(), 24'h346856);
        goto(420);  chk("l5_px3_rgb", rgb(), 24'h081820);
        goto(458);  chk("l5_lastpx_rgb", rgb(), 24'h081820);
        goto(459);  chk("l5_right_border_rgb", rgb(), 0);
                    chk("l5_right_border_de", De, 1);

        // Rows of the scaled image row 0 and start of row 1
        goto(494);  chk("l6_px1_rgb", rgb(), 24'h88C070);
`ifdef SCANOUT_SCANLINES_EN
        goto(574);  chk("l7_px1_rgb", rgb(), 24'h446038);
`else
        goto(574);  chk("l7_px1_rgb", rgb(), 24'h88C070);
`endif
        goto(649);  chk("l8_addr", RdAddress, 16'h0100);
                    chk("l8_en", RdClockEn, 1);
        goto(654);  chk("l8_px1_rgb", rgb(), 24'h88C070);

        // Last read of the frame and hold after it
        goto(2776); chk("last_addr", RdAddress, 16'h090F);
                    chk("last_en", RdClockEn, 1);
        goto(2777); chk("after_last_en", RdClockEn, 0);
                    chk("after_last_addr", RdAddress, 16'h090F);

        // Vertical timing
        goto(3123); chk("de_line39", De, 1);
        goto(3203); chk("de_line40", De, 0);
        goto(3362); chk("vs_before", Vsync, 1);
        goto(3363); chk("vs_first", Vsync, 0);
        goto(3522); chk("vs_last", Vsync, 0);
        goto(3523); chk("vs_after", Vsync, 1);

        // Second frame: 3840 clocks per frame
        goto(3842); chk("f2_fs_before", FrameStart, 0);
        goto(3843); chk("f2_fs", FrameStart, 1);
        goto(4249); chk("f2_addr_first", RdAddress, 16'h0000);
        goto(4251); chk("f2_px0_rgb", rgb(), 24'hE0F8D0);
        goto(4489); chk("f2_l8_addr", RdAddress, 16'h0100);
        goto(7682); chk("f3_fs_before", FrameStart, 0);
        goto(7683); chk("f3_fs", FrameStart, 1);

        // Mid-line reset at h=30, v=20 of the third frame
        goto(9310); chk("pre_rst_rgb", rgb(), 24'h346856);
                    chk("pre_rst_de", De, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_hs",  Hsync, 1);
        chk("mid_rst_vs",  Vsync, 1);
        chk("mid_rst_de",  De, 0);
        chk("mid_rst_rgb", rgb(), 0);
        chk("mid_rst_en",  RdClockEn, 0);
        chk("mid_rst_fs",  FrameStart, 0);
        rst = 1'b0;
        goto(1);    chk("post_rst_c1_en", RdClockEn, 0);
                    chk("post_rst_c1_de", De, 0);
        goto(2);    chk("post_rst_c2_fs", FrameStart, 0);
                    chk("post_rst_c2_rgb", rgb(), 0);
        goto(3);    chk("post_rst_c3_fs", FrameStart, 1);
                    chk("post_rst_c3_de", De, 1);
        goto(411);  chk("post_rst_px0_rgb", rgb(), 24'hE0F8D0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
